// File: rtl/div_seq_ctrl_if.sv
// Handshake and result bundle for the sequential divider; master drives requests, slave answers.
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Signed non-restoring divider, one quotient bit per clock; done WIDTH+2 edges after start (2 on /0).
// No backpressure: start is only sampled in IDLE, results are held until the next accepted start.
module div_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    div_seq_ctrl_if.slave      bus
);
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;

    logic [WIDTH-1:0] w_abs_dvd;
    logic [WIDTH-1:0] w_abs_dvs;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_step;
    logic [WIDTH-1:0] w_fix;

    assign w_abs_dvd = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
    assign w_abs_dvs = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
    assign w_shift   = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
    assign w_step    = r_rem[WIDTH] ? (w_shift + {1'b0, r_dvs}) : (w_shift - {1'b0, r_dvs});
    // After restore the remainder is in [0, |divisor|), so the low WIDTH bits carry it fully.
    assign w_fix     = r_rem[WIDTH] ? (r_rem[WIDTH-1:0] + r_dvs) : r_rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_dz        <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            r_quotient  <= '1;
                            r_remainder <= '1;
                            r_dz        <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_quo    <= w_abs_dvd;
                            r_dvs    <= w_abs_dvs;
                            r_sign_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_sign_r <= bus.dividend[WIDTH-1];
                            r_rem    <= '0;
                            r_cnt    <= '0;
                            r_busy   <= 1'b1;
                            r_state  <= S_ITER;
                        end
                    end
                end
                S_ITER: begin
                    r_rem <= w_step;
                    r_quo <= {r_quo[WIDTH-2:0], ~w_step[WIDTH]};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_quotient  <= r_sign_q ? -r_quo : r_quo;
                    r_remainder <= r_sign_r ? -w_fix : w_fix;
                    r_dz        <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    // The divide-by-zero path arrives with done still low and spends one extra cycle here.
                    if (r_done) begin
                        r_done  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dz;
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomised and directed checks of div_seq_ctrl against a plain-arithmetic signed division model.
module tb_div_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    logic [31:0] prev_q;
    logic [31:0] prev_r;

    div_seq_ctrl_if #(.WIDTH(32)) bus ();

    div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = 32'hFFFF_FFFF;
            dz = 1'b1;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
            dz = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          done_k;
        int          done_n;
        int          busy_n;
        int          exp_lat;
        int          exp_busy;
        ref_div(a, b, eq, er, edz);
        exp_lat  = (b == 32'd0) ? 1 : 33;
        exp_busy = (b == 32'd0) ? 0 : 33;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk);
        @(negedge clk);
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        done_k = -1;
        done_n = 0;
        busy_n = 0;
        for (int k = 0; k < 45; k++) begin
            if (k > 0) @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_k < 0) done_k = k;
            end
            if (k == 10 && b != 32'd0) begin
                n_checks++;
                if (bus.quotient !== prev_q || bus.remainder !== prev_r) begin
                    n_fail++;
                    $display("FAIL %s held_result got q=%h r=%h want q=%h r=%h",
                             name, bus.quotient, bus.remainder, prev_q, prev_r);
                end
            end
        end
        n_checks++;
        if (done_k !== exp_lat) begin
            n_fail++;
            $display("FAIL %s latency got %0d want %0d", name, done_k, exp_lat);
        end
        n_checks++;
        if (done_n !== 1) begin
            n_fail++;
            $display("FAIL %s done_count got %0d want 1", name, done_n);
        end
        n_checks++;
        if (busy_n !== exp_busy) begin
            n_fail++;
            $display("FAIL %s busy_cycles got %0d want %0d", name, busy_n, exp_busy);
        end
        n_checks++;
        if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edz) begin
            n_fail++;
            $display("FAIL %s result got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     name, bus.quotient, bus.remainder, bus.div_by_zero, eq, er, edz);
        end
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic check_idle_zero(input string name);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 32'd0 ||
            bus.remainder !== 32'd0 || bus.div_by_zero !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got busy=%b done=%b q=%h r=%h dz=%b want all zero",
                     name, bus.busy, bus.done, bus.quotient, bus.remainder, bus.div_by_zero);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #2;
        check_idle_zero("reset_async");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("reset_release");
        prev_q = '0;
        prev_r = '0;
    endtask

    task automatic test_directed();
        run_op(32'd7,          32'd2,          "7_div_2");
        run_op(-32'sd7,        32'd2,          "m7_div_2");
        run_op(32'd7,          -32'sd2,        "7_div_m2");
        run_op(32'h1234_5678,  32'd0,          "div_zero");
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  "intmin_div_m1");
        run_op(32'd0,          32'd5,          "0_div_5");
        run_op(32'h8000_0000,  32'h8000_0000,  "intmin_div_intmin");
        run_op(32'd5,          32'h8000_0000,  "5_div_intmin");
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 30; i++) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0:       b = $urandom;
                1:       b = 32'($urandom_range(1, 20));
                2:       b = -32'($urandom_range(1, 20));
                3:       b = 32'd0;
                default: begin a = 32'h8000_0000; b = $urandom; end
            endcase
            run_op(a, b, $sformatf("random_%0d", i));
        end
    endtask

    task automatic test_hold_start();
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        int          done_n;
        ref_div(32'd1000, 32'd7, eq, er, edz);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd1000;
        bus.divisor  = 32'd7;
        @(posedge clk);
        done_n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.done) begin
                done_n++;
                bus.start = 1'b0;
            end else if (bus.start) begin
                bus.dividend = $urandom;
                bus.divisor  = $urandom | 32'd1;
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (done_n !== 1) begin
            n_fail++;
            $display("FAIL hold_start done_count got %0d want 1", done_n);
        end
        n_checks++;
        if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edz) begin
            n_fail++;
            $display("FAIL hold_start result got q=%h r=%h want q=%h r=%h",
                     bus.quotient, bus.remainder, eq, er);
        end
        prev_q = eq;
        prev_r = er;
    endtask

    task automatic test_reset_mid();
        int done_n;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 32'd100;
        bus.divisor  = 32'd3;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_zero("reset_mid_op");
        done_n = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        n_checks++;
        if (done_n !== 0) begin
            n_fail++;
            $display("FAIL reset_mid done_after_abort got %0d want 0", done_n);
        end
        check_idle_zero("reset_mid_idle");
        prev_q = '0;
        prev_r = '0;
        run_op(32'd100, 32'd3, "after_reset_100_div_3");
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_hold_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
